// File: rtl/fifo_wr_arbiter_if.sv
// Bus between the producers, the write arbiter and fifo_core's write side.
// The master modport is the producer/FIFO side. The slave modport is the arbiter.
interface fifo_wr_arbiter_if #(
   parameter int WIDTH         = 8,
   parameter int NUM_REQ       = 4,
   parameter int POINTER_WIDTH = 4
);
   localparam int GID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic [NUM_REQ-1:0]       req_valid;
   logic [NUM_REQ*WIDTH-1:0] req_data;
   logic [NUM_REQ-1:0]       req_ready;
   logic                     fifo_full;
   logic [POINTER_WIDTH:0]   fifo_count;
   logic                     fifo_wr_en;
   logic [WIDTH-1:0]         fifo_input_data;
   logic [GID_W-1:0]         grant_id;
   logic                     busy;

   modport master (
      output req_valid,
      output req_data,
      input  req_ready,
      output fifo_full,
      output fifo_count,
      input  fifo_wr_en,
      input  fifo_input_data,
      input  grant_id,
      input  busy
   );

   modport slave (
      input  req_valid,
      input  req_data,
      output req_ready,
      input  fifo_full,
      input  fifo_count,
      output fifo_wr_en,
      output fifo_input_data,
      output grant_id,
      output busy
   );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing fifo_core's single write port between NUM_REQ
// producers. Each grant lasts up to MAX_BURST beats. One IDLE bubble separates
// consecutive grants.
// Optional macro FIFO_ARB_WATERMARK_EN: new grants are also held off while
// fifo_count >= WATERMARK, leaving headroom for a burst already in progress.
module fifo_wr_arbiter #(
   parameter int WIDTH         = 8,
   parameter int NUM_REQ       = 4,
   parameter int POINTER_WIDTH = 4,
   parameter int MAX_BURST     = 4,
   parameter int WATERMARK     = 12
) (
   input  logic                 clk,
   input  logic                 reset,
   fifo_wr_arbiter_if.slave     bus
);
   localparam int GID_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int BURST_W = 4;
   localparam int CNT_W   = POINTER_WIDTH + 1;

   localparam logic [0:0] IDLE  = 1'b0;
   localparam logic [0:0] GRANT = 1'b1;

   logic [0:0]         state;
   logic [GID_W-1:0]   grant_id;
   logic [GID_W-1:0]   prio;
   logic [BURST_W-1:0] burst_cnt;

   logic               grant_blocked;
   logic               any_found;
   logic [GID_W-1:0]   pick;
   int unsigned        idx;
   logic               gnt_valid;
   logic               beat;
   logic               last_beat;
   logic               release_grant;

`ifdef FIFO_ARB_WATERMARK_EN
   // A new grant waits for space, either because the FIFO is full or because it has reached the watermark.
   always_comb begin
      grant_blocked = bus.fifo_full || (bus.fifo_count >= CNT_W'(WATERMARK));
   end
`else
   logic [CNT_W-1:0] count_unused;
   assign count_unused = bus.fifo_count;

   // A new grant is held off only by a full FIFO.
   always_comb begin
      grant_blocked = bus.fifo_full;
   end
`endif

   // Find the first valid producer. The search starts at prio and wraps around.
   always_comb begin
      any_found = 1'b0;
      pick      = '0;
      idx       = 0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         idx = int'(prio) + k;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         if (!any_found && bus.req_valid[idx]) begin
            any_found = 1'b1;
            pick      = GID_W'(idx);
         end
      end
   end

   // Decide the beat and the release for the granted producer.
   always_comb begin
      gnt_valid     = bus.req_valid[grant_id];
      beat          = (state == GRANT) && gnt_valid && !bus.fifo_full;
      last_beat     = beat && (burst_cnt == BURST_W'(MAX_BURST - 1));
      release_grant = (state == GRANT) && (last_beat || (!gnt_valid && !beat));
   end

   // Drive the handshake and the FIFO write port from the current grant.
   always_comb begin
      bus.req_ready       = '0;
      bus.fifo_wr_en      = beat;
      bus.fifo_input_data = '0;
      if ((state == GRANT) && !bus.fifo_full) bus.req_ready[grant_id] = 1'b1;
      if (beat) bus.fifo_input_data = bus.req_data[int'(grant_id)*WIDTH +: WIDTH];
      bus.grant_id = grant_id;
      bus.busy     = (state == GRANT);
   end

   // Control FSM: grant in IDLE, count beats and release in GRANT, advance the priority pointer.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state     <= IDLE;
         grant_id  <= '0;
         prio      <= '0;
         burst_cnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (any_found && !grant_blocked) begin
                  grant_id  <= pick;
                  burst_cnt <= '0;
                  state     <= GRANT;
               end
            end
            GRANT: begin
               if (beat) burst_cnt <= burst_cnt + BURST_W'(1);
               if (release_grant) begin
                  state <= IDLE;
                  if (int'(grant_id) == NUM_REQ - 1) prio <= '0;
                  else prio <= grant_id + GID_W'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
